// File: rtl/icache_pkg.sv
`default_nettype none
//==============================================================================
// Module      : icache_pkg
// Description : Types and constants shared by the instruction cache controller
//               and its line store.
//                 icacheState - controller FSM states (IDLE/REQUEST/WAIT)
//                 LINE_BITS   - width of one cache line (two instructions)
//                 WORD_BITS   - width of one instruction word
//                 line_addr() - clears the in-line byte offset of an address
// Revision    : 1.0 - initial release
//==============================================================================
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        WAIT    = 2'd2
    } icacheState;

    localparam int LINE_BITS = 64;
    localparam int WORD_BITS = 32;

    // A line holds two 32-bit words, so the line base is the address with
    // bits [2:0] cleared.
    function automatic logic [31:0] line_addr(input logic [31:0] pc);
        return {pc[31:3], 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_line_store.sv
`default_nettype none
//==============================================================================
// Module      : icache_line_store
// Description : Data, tag and valid storage for the direct-mapped icache.
//               Asynchronous read port for the lookup, one synchronous write
//               port for line fills, and a flush that clears every valid bit.
//               Only the valid bits are reset; tag and data contents are
//               meaningless until the matching valid bit is set.
// Ports       : clk, reset (async, active-low)
//               rd_index -> rd_valid, rd_tag, rd_line   (combinational read)
//               wr_en, wr_index, wr_tag, wr_line        (fill on clk edge)
//               flush_all                               (clear all valid bits)
// Revision    : 1.0 - initial release
//==============================================================================
module icache_line_store
    import icache_pkg::*;
#(
    parameter int numLines  = 8,
    parameter int indexBits = $clog2(numLines),
    parameter int TAG_BITS  = 32 - 3 - indexBits
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [indexBits-1:0] rd_index,
    output logic                 rd_valid,
    output logic [TAG_BITS-1:0]  rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic                 wr_en,
    input  logic [indexBits-1:0] wr_index,
    input  logic [TAG_BITS-1:0]  wr_tag,
    input  logic [LINE_BITS-1:0] wr_line,
    input  logic                 flush_all
);

    logic [numLines-1:0]  valid;
    logic [TAG_BITS-1:0]  tag_mem  [numLines];
    logic [LINE_BITS-1:0] data_mem [numLines];

    // Flush wins over a coincident fill so an invalidate is never undone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (flush_all) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_line  = data_mem[rd_index];

endmodule
`default_nettype wire

// File: rtl/icache_controller.sv
`default_nettype none
//==============================================================================
// Module      : icache_controller
// Description : Direct-mapped instruction cache between fetch and instruction
//               memory. Hits are served combinationally; a miss stalls fetch,
//               issues a one-cycle memory request and fills a 64-bit line when
//               the memory answers. Supports full flush and keeps saturating
//               hit/miss counters.
// Ports       : clk, reset (async, active-low)
//               fetchPC, fetchValid, flush          - from fetch
//               instruction, instructionValid, stall - to fetch
//               memPC, memRequest                    - to memory
//               memLineData, memReceived             - from memory
//               hitCount, missCount                  - performance counters
// Revision    : 1.0 - initial release
//==============================================================================
module icache_controller
    import icache_pkg::*;
#(
    parameter int numLines  = 8,
    parameter int indexBits = $clog2(numLines)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          fetchPC,
    input  logic                 fetchValid,
    input  logic                 flush,
    output logic [WORD_BITS-1:0] instruction,
    output logic                 instructionValid,
    output logic                 stall,
    output logic [31:0]          memPC,
    output logic                 memRequest,
    input  logic [LINE_BITS-1:0] memLineData,
    input  logic                 memReceived,
    output logic [31:0]          hitCount,
    output logic [31:0]          missCount
);

    localparam int TAG_BITS = 32 - 3 - indexBits;

    icacheState state;
    icacheState state_next;

    logic [31:0] miss_pc;
    logic        drop_fill;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    logic                 lookup_valid;
    logic [TAG_BITS-1:0]  lookup_tag;
    logic [LINE_BITS-1:0] lookup_line;

    logic hit;
    logic start_miss;
    logic fill_en;

    // Byte-within-word bits never take part in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^fetchPC[1:0];

    icache_line_store #(
        .numLines  (numLines),
        .indexBits (indexBits),
        .TAG_BITS  (TAG_BITS)
    ) u_line_store (
        .clk       (clk),
        .reset     (reset),
        .rd_index  (fetchPC[3 +: indexBits]),
        .rd_valid  (lookup_valid),
        .rd_tag    (lookup_tag),
        .rd_line   (lookup_line),
        .wr_en     (fill_en),
        .wr_index  (miss_pc[3 +: indexBits]),
        .wr_tag    (miss_pc[31:3+indexBits]),
        .wr_line   (memLineData),
        .flush_all (flush)
    );

    // Next-state and outputs
    always_comb begin
        state_next       = state;
        instruction      = '0;
        instructionValid = 1'b0;
        stall            = 1'b0;
        memPC            = 32'd0;
        memRequest       = 1'b0;
        hit              = 1'b0;
        start_miss       = 1'b0;
        fill_en          = 1'b0;

        case (state)
            IDLE: begin
                if (fetchValid) begin
                    // A flush this cycle invalidates the array, so the lookup
                    // must not report the stale line as a hit.
                    if (lookup_valid && (lookup_tag == fetchPC[31:3+indexBits]) && !flush) begin
                        hit              = 1'b1;
                        instructionValid = 1'b1;
                        instruction      = fetchPC[2] ? lookup_line[WORD_BITS-1:0]
                                                      : lookup_line[LINE_BITS-1:WORD_BITS];
                    end else begin
                        stall = 1'b1;
                        // The fill is deferred to the next cycle's lookup when
                        // a flush is in progress.
                        if (!flush) begin
                            start_miss = 1'b1;
                            state_next = REQUEST;
                        end
                    end
                end
            end

            REQUEST: begin
                memRequest = 1'b1;
                memPC      = line_addr(miss_pc);
                stall      = 1'b1;
                state_next = WAIT;
            end

            WAIT: begin
                stall = 1'b1;
                memPC = line_addr(miss_pc);
                if (memReceived) begin
                    // A flush arriving with the response also discards it.
                    fill_en    = !drop_fill && !flush;
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_pc <= 32'd0;
        end else if (start_miss) begin
            miss_pc <= fetchPC;
        end
    end

    // Remembers that the outstanding response belongs to a flushed cache.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_fill <= 1'b0;
        end else if (state == WAIT && memReceived) begin
            drop_fill <= 1'b0;
        end else if (flush && state != IDLE) begin
            drop_fill <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt  <= 32'd0;
            miss_cnt <= 32'd0;
        end else begin
            if (hit && hit_cnt != 32'hFFFF_FFFF) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (start_miss && miss_cnt != 32'hFFFF_FFFF) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end

    assign hitCount  = hit_cnt;
    assign missCount = miss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_icache_controller.sv
`default_nettype none
//==============================================================================
// Module      : tb_icache_controller
// Description : Table-driven bench for icache_controller. Each record holds
//               one cycle of fetch/memory inputs and the expected outputs for
//               that cycle. Counter values and the mid-miss reset are checked
//               by hand-written sequences between table segments.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_icache_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetchPC;
    logic        fetchValid;
    logic        flush;
    logic [31:0] instruction;
    logic        instructionValid;
    logic        stall;
    logic [31:0] memPC;
    logic        memRequest;
    logic [63:0] memLineData;
    logic        memReceived;
    logic [31:0] hitCount;
    logic [31:0] missCount;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    icache_controller #(.numLines(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .fetchPC          (fetchPC),
        .fetchValid       (fetchValid),
        .flush            (flush),
        .instruction      (instruction),
        .instructionValid (instructionValid),
        .stall            (stall),
        .memPC            (memPC),
        .memRequest       (memRequest),
        .memLineData      (memLineData),
        .memReceived      (memReceived),
        .hitCount         (hitCount),
        .missCount        (missCount)
    );

    // Memory image: two fixed words at 0 and 4, a recognisable pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0113;
            32'h0000_0004: return 32'h0030_0193;
            default:       return 32'hA500_0000 ^ a;
        endcase
    endfunction

    function automatic logic [63:0] line_image(input logic [31:0] a);
        return {mem_word({a[31:3], 3'b000}), mem_word({a[31:3], 3'b100})};
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic        rcv;
        logic        stl;
        logic        iv;
        logic [31:0] ins;
        logic        req;
        logic [31:0] mpc;
    } vec_t;

    vec_t tv[64];
    int   nv = 0;
    int   seg = 0;

    task automatic add(input logic [31:0] pc, input logic fv, input logic fl,
                       input logic rcv, input logic stl, input logic iv,
                       input logic [31:0] ins, input logic req,
                       input logic [31:0] mpc);
        tv[nv].pc  = pc;
        tv[nv].fv  = fv;
        tv[nv].fl  = fl;
        tv[nv].rcv = rcv;
        tv[nv].stl = stl;
        tv[nv].iv  = iv;
        tv[nv].ins = ins;
        tv[nv].req = req;
        tv[nv].mpc = mpc;
        nv++;
    endtask

    // Four-cycle miss with single-cycle memory: miss, REQUEST, WAIT+receive, hit.
    task automatic add_fill(input logic [31:0] pc, input logic [31:0] word);
        logic [31:0] base;
        base = {pc[31:3], 3'b000};
        add(pc, 1, 0, 0, 1, 0, 32'd0, 0, 32'd0);
        add(pc, 1, 0, 0, 1, 0, 32'd0, 1, base);
        add(pc, 1, 0, 1, 1, 0, 32'd0, 0, base);
        add(pc, 1, 0, 0, 0, 1, word,  0, 32'd0);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s (vector %0d): got %h, expected %h", nm, idx, got, exp);
        end
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic run_segment();
        for (int i = seg; i < nv; i++) begin
            fetchPC     = tv[i].pc;
            fetchValid  = tv[i].fv;
            flush       = tv[i].fl;
            memReceived = tv[i].rcv;
            memLineData = line_image(tv[i].mpc);
            #2;
            chk("stall",            i, {31'd0, stall},            {31'd0, tv[i].stl});
            chk("instructionValid", i, {31'd0, instructionValid}, {31'd0, tv[i].iv});
            chk("instruction",      i, instruction,               tv[i].ins);
            chk("memRequest",       i, {31'd0, memRequest},       {31'd0, tv[i].req});
            chk("memPC",            i, memPC,                     tv[i].mpc);
            @(posedge clk);
            #1;
        end
        seg = nv;
    endtask

    task automatic chk_counters(input string nm, input logic [31:0] hits,
                                input logic [31:0] misses);
        chk({nm, " hitCount"},  -1, hitCount,  hits);
        chk({nm, " missCount"}, -1, missCount, misses);
    endtask

    initial begin
        reset       = 1'b0;
        fetchPC     = 32'd0;
        fetchValid  = 1'b0;
        flush       = 1'b0;
        memReceived = 1'b0;
        memLineData = 64'd0;

        // Reset state
        #12;
        chk("reset instruction",      -1, instruction, 32'd0);
        chk("reset instructionValid", -1, {31'd0, instructionValid}, 32'd0);
        chk("reset stall",            -1, {31'd0, stall}, 32'd0);
        chk("reset memRequest",       -1, {31'd0, memRequest}, 32'd0);
        chk("reset memPC",            -1, memPC, 32'd0);
        chk_counters("reset", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Spurious post-reset receive, then cold miss of PC 0
        add(32'h00, 0, 0, 1, 0, 0, 32'd0, 0, 32'd0);
        add(32'h00, 1, 0, 0, 1, 0, 32'd0, 0, 32'd0);
        add(32'h00, 1, 0, 0, 1, 0, 32'd0, 1, 32'd0);
        add(32'h00, 1, 0, 1, 1, 0, 32'd0, 0, 32'd0);
        add(32'h00, 1, 0, 0, 0, 1, 32'h0050_0113, 0, 32'd0);
        run_segment();
        chk_counters("cold", 32'd1, 32'd1);

        // Spatial hit in the same line
        add(32'h04, 1, 0, 0, 0, 1, 32'h0030_0193, 0, 32'd0);
        run_segment();
        chk_counters("spatial", 32'd2, 32'd1);

        // Conflict eviction: 0x40 shares index 0 with 0x00
        add_fill(32'h40, 32'hA500_0040);
        add_fill(32'h00, 32'h0050_0113);
        run_segment();
        chk_counters("conflict", 32'd4, 32'd3);

        // Flush during WAIT of a 0x08 miss: response discarded, refetch misses
        add(32'h08, 1, 0, 0, 1, 0, 32'd0, 0, 32'd0);
        add(32'h08, 1, 0, 0, 1, 0, 32'd0, 1, 32'h08);
        add(32'h08, 1, 1, 1, 1, 0, 32'd0, 0, 32'h08);
        add_fill(32'h08, 32'hA500_0008);
        add_fill(32'h00, 32'h0050_0113);
        run_segment();
        chk_counters("flush_wait", 32'd6, 32'd6);

        // Reset while in REQUEST
        add(32'h10, 1, 0, 0, 1, 0, 32'd0, 0, 32'd0);
        run_segment();
        #2;
        chk("mid-miss memRequest", -1, {31'd0, memRequest}, 32'd1);
        chk("mid-miss memPC",      -1, memPC, 32'h10);
        #1;
        reset      = 1'b0;
        fetchValid = 1'b0;
        #1;
        chk("async reset memRequest", -1, {31'd0, memRequest}, 32'd0);
        chk("async reset stall",      -1, {31'd0, stall}, 32'd0);
        chk("async reset memPC",      -1, memPC, 32'd0);
        @(posedge clk);
        #1;
        chk_counters("mid-miss reset", 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Stale receive after reset, then loop 0,4,8,12,16,20,16,20
        add(32'h10, 0, 0, 1, 0, 0, 32'd0, 0, 32'd0);
        add_fill(32'h00, 32'h0050_0113);
        add(32'h04, 1, 0, 0, 0, 1, 32'h0030_0193, 0, 32'd0);
        add_fill(32'h08, 32'hA500_0008);
        add(32'h0C, 1, 0, 0, 0, 1, 32'hA500_000C, 0, 32'd0);
        add_fill(32'h10, 32'hA500_0010);
        add(32'h14, 1, 0, 0, 0, 1, 32'hA500_0014, 0, 32'd0);
        add(32'h10, 1, 0, 0, 0, 1, 32'hA500_0010, 0, 32'd0);
        add(32'h14, 1, 0, 0, 0, 1, 32'hA500_0014, 0, 32'd0);
        run_segment();
        chk_counters("loop", 32'd8, 32'd3);

        // Flush in IDLE forces a miss without starting a fill; idle fetch
        add(32'h10, 1, 1, 0, 1, 0, 32'd0, 0, 32'd0);
        add(32'h10, 0, 0, 0, 0, 0, 32'd0, 0, 32'd0);
        add_fill(32'h10, 32'hA500_0010);
        run_segment();
        chk_counters("flush_idle", 32'd9, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/icache_controller.md
# icache_controller

Direct-mapped instruction cache controller between the fetch stage and `instructionMemory`. Serves hits combinationally in the same cycle. On a miss it stalls fetch, runs the memory request/response handshake, and fills a 64-bit (two-instruction) line from the memory's `cacheData` output. It also supports a full invalidate (flush) and keeps hit/miss counters for performance debug.

## Interface
Parameters:
- `numLines`, default 8: number of cache lines; power of two, ≥ 2.
- `indexBits`, default `$clog2(numLines)`: index width, derived.

Ports (reset is asynchronous, active-low, named `reset`; the clock is `clk`):
- `clk`  in  1  clock
- `reset`  in  1  asynchronous active-low reset
- `fetchPC`  in  32  PC requested by fetch
- `fetchValid`  in  1  fetch wants an instruction this cycle
- `flush`  in  1  invalidate all lines (e.g. after a self-modifying store)
- `instruction`  out  32  instruction for `fetchPC` when `instructionValid`
- `instructionValid`  out  1  hit this cycle
- `stall`  out  1  fetch must hold `fetchPC`
- `memPC`  out  32  line-aligned miss address to memory
- `memRequest`  out  1  request to memory
- `memLineData`  in  64  memory `cacheData`
- `memReceived`  in  1  memory `receivedInstruction`
- `hitCount`  out  32  saturating hit counter
- `missCount`  out  32  saturating miss counter

## Operation
- Address split: offset `pc[2]` (word in line), index `pc[3+indexBits-1:3]`, tag `pc[31:3+indexBits]`. `pc[1:0]` is ignored.
- Line layout: `memLineData[63:32]` is the even word (`pc[2]=0`); `memLineData[31:0]` is the odd word.
- States, one-hot or enum:
  - **IDLE**: lookup. Hit = `fetchValid` & `valid[index]` & (tag match). On a hit: `instructionValid=1`, `stall=0`, `instruction` = the selected word. On a miss: `stall=1`, latch `missPC`, go to **REQUEST**.
  - **REQUEST**: `memRequest=1`, `memPC={missPC[31:3],3'b0}`, `stall=1`, go to **WAIT**.
  - **WAIT**: `stall=1`, `memPC` held. When `memReceived=1`, write the data array, tag and valid bit at the index of `missPC`, then go to **IDLE**. The write is skipped if `dropFill` is set.
- `memReceived` is ignored outside WAIT. The memory raises it for one cycle after its own reset; that pulse must not fill the cache.
- Flush: clears all valid bits at the next edge in any state. If asserted in REQUEST or WAIT, set `dropFill`. The pending response is still consumed and then discarded, and the FSM returns to IDLE. `dropFill` clears on leaving WAIT.
- A flush in IDLE forces that cycle's lookup to report a miss, with no fill started that cycle.
- `fetchValid=0` in IDLE: no lookup, `stall=0`, counters unchanged.
- Counters:
  - `hitCount` increments on each IDLE hit.
  - `missCount` increments on each IDLE→REQUEST transition.
  - Both saturate at `32'hFFFF_FFFF`.
- Reset values:
  - state IDLE; all valid bits 0; `dropFill` 0; counters 0.
  - outputs `instruction=0`, `instructionValid=0`, `stall=0`, `memRequest=0`, `memPC=0`.
  - The tag and data arrays are not reset.
- A reset mid-miss returns the FSM to IDLE. Any later `memReceived` is ignored.

## Timing
- Hit latency is 0 cycles (combinational from `fetchPC`).
- Miss with the current memory (single-cycle receive→pass):
  - cycle T: miss detected
  - T+1: REQUEST
  - T+2: `memReceived` seen, line written at the end of the cycle
  - T+3: IDLE hit returns the instruction
- Miss penalty is therefore 3 stall cycles. Longer memory latency simply extends WAIT.
- `memRequest` is a 1-cycle pulse per miss. It is never reasserted while in WAIT.
- Fetch holds `fetchPC` while `stall=1`. The controller uses only the latched `missPC` for the fill.

## Structure
- Shared package `icache_pkg`:
  - the `icacheState` enum (IDLE/REQUEST/WAIT)
  - the `LINE_BITS=64` and `WORD_BITS=32` constants
  - a helper to compute the line-aligned address
- Sub-module `icache_line_store` holds the data, tag and valid arrays:
  - async read port for lookup
  - one sync write port for fill
  - a flush-all input for the valid bits
- The FSM and counters live in `icache_controller`.

## Test plan
- **Cold miss.** After reset, `fetchPC=0`, `fetchValid=1`.
  - Expect: `stall` for 3 cycles, one `memRequest` with `memPC=0`, then `instruction=32'h00500113` with `instructionValid`.
  - Expect: `missCount=1`, `hitCount=1`.
- **Spatial hit.** After the line 0 fill, `fetchPC=4`.
  - Expect: same-cycle `instruction=32'h00300193`, no `memRequest`, `hitCount` incremented.
- **Post-reset spurious receive.** Memory asserts `memReceived` in the first cycle after reset while the controller is in IDLE.
  - Expect: no valid bit set; the next lookup of PC 0 misses.
- **Conflict eviction** (`numLines=8`). Fill PC `0x00`, then fetch PC `0x40` (same index, different tag).
  - Expect: a miss, `memPC=0x40`, line replaced.
  - Expect: re-fetching PC `0x00` misses again; `missCount=3`.
- **Flush during WAIT.** Assert `flush` in the WAIT cycle of a PC `0x08` miss.
  - Expect: the response is consumed, the FSM returns to IDLE, and the line is not valid.
  - Expect: fetch of `0x08` misses again with `memPC=0x08`.
- **Loop behaviour.** Run the PC sequence 0,4,8,12,16,20,16,20…
  - Expect: misses only on first touch of lines 0, 1 and 2 (`missCount=3`); all repeats hit.
